// File: rtl/pp_axis2mat_frame_sched.sv
// Frame-level controller for the AxiStream2MatStream converter: derives per-frame
// FIFO parameters from the frame geometry and sequences the converter handshake.
module pp_axis2mat_frame_sched #(
    parameter int PIX_PER_WORD = 8,
    parameter int FCNT_W       = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_start,
    input  logic [31:0]       cfg_width,
    input  logic [31:0]       cfg_height,
    input  logic [FCNT_W-1:0] cfg_num_frames,
    input  logic              cfg_stop,
    output logic              busy,
    output logic              err_cfg,
    output logic [FCNT_W-1:0] frames_done,
    output logic [31:0]       rows_din,
    input  logic              rows_full_n,
    output logic              rows_write,
    output logic [31:0]       cols_bound_per_npc_din,
    input  logic              cols_bound_per_npc_full_n,
    output logic              cols_bound_per_npc_write,
    output logic [3:0]        last_blk_width,
    output logic              conv_ap_start,
    input  logic              conv_ap_done,
    input  logic              conv_ap_ready,
    output logic              conv_ap_continue
);
    localparam int LOG2_PPW = $clog2(PIX_PER_WORD);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_PUSH, S_RUN, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [31:0]       width_q, width_d;
    logic [31:0]       height_q, height_d;
    logic [FCNT_W-1:0] num_frames_q, num_frames_d;
    logic [31:0]       rows_din_q, rows_din_d;
    logic [31:0]       cols_din_q, cols_din_d;
    logic [3:0]        lbw_q, lbw_d;
    logic              rows_done_q, rows_done_d;
    logic              cols_done_q, cols_done_d;
    logic [FCNT_W-1:0] frames_done_q, frames_done_d;
    logic [FCNT_W-1:0] run_cnt_q, run_cnt_d;
    logic              err_q, err_d;
    logic              stop_q, stop_d;

    // Ready always coincides with done, so done alone drives the FSM.
    logic unused_ready;
    assign unused_ready = conv_ap_ready;

    function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Ceil(width / PIX_PER_WORD) without forming width + PIX_PER_WORD - 1,
    // so a 32-bit datapath cannot overflow even at width = 2^32-1.
    function automatic logic [31:0] words_per_row(input logic [31:0] w);
        return (w >> LOG2_PPW) + {31'd0, |w[LOG2_PPW-1:0]};
    endfunction

    function automatic logic [3:0] tail_pixels(input logic [LOG2_PPW-1:0] rem);
        return (rem == '0) ? 4'(PIX_PER_WORD) : 4'(rem);
    endfunction

    assign busy                     = (state_q != S_IDLE);
    assign conv_ap_start            = (state_q == S_RUN);
    assign conv_ap_continue         = (state_q == S_ACK);
    assign rows_write               = (state_q == S_PUSH) && !rows_done_q && rows_full_n;
    assign cols_bound_per_npc_write = (state_q == S_PUSH) && !cols_done_q && cols_bound_per_npc_full_n;
    assign err_cfg                  = err_q;
    assign frames_done              = frames_done_q;
    assign rows_din                 = rows_din_q;
    assign cols_bound_per_npc_din   = cols_din_q;
    assign last_blk_width           = lbw_q;

    always_comb begin
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        num_frames_d  = num_frames_q;
        rows_din_d    = rows_din_q;
        cols_din_d    = cols_din_q;
        lbw_d         = lbw_q;
        rows_done_d   = rows_done_q;
        cols_done_d   = cols_done_q;
        frames_done_d = frames_done_q;
        run_cnt_d     = run_cnt_q;
        err_d         = err_q;
        stop_d        = stop_q;

        if (busy && cfg_stop) stop_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    width_d       = cfg_width;
                    height_d      = cfg_height;
                    num_frames_d  = cfg_num_frames;
                    frames_done_d = '0;
                    run_cnt_d     = '0;
                    err_d         = 1'b0;
                    stop_d        = 1'b0;
                    state_d       = S_CALC;
                end
            end
            S_CALC: begin
                lbw_d = tail_pixels(width_q[LOG2_PPW-1:0]);
                if (width_q == '0 || height_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rows_din_d  = height_q;
                    cols_din_d  = words_per_row(width_q);
                    rows_done_d = 1'b0;
                    cols_done_d = 1'b0;
                    state_d     = S_PUSH;
                end
            end
            S_PUSH: begin
                if (rows_write)               rows_done_d = 1'b1;
                if (cols_bound_per_npc_write) cols_done_d = 1'b1;
                if (rows_done_d && cols_done_d) state_d = S_RUN;
            end
            S_RUN: begin
                if (conv_ap_done) state_d = S_ACK;
            end
            S_ACK: begin
                frames_done_d = sat_inc(frames_done_q);
                run_cnt_d     = run_cnt_q + 1'b1;
                // The run counter wraps freely; frames_done saturates for reporting only.
                if (stop_q || cfg_stop || (num_frames_q != '0 && run_cnt_d == num_frames_q)) begin
                    state_d = S_IDLE;
                end else begin
                    rows_done_d = 1'b0;
                    cols_done_d = 1'b0;
                    state_d     = S_PUSH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            width_q       <= '0;
            height_q      <= '0;
            num_frames_q  <= '0;
            rows_din_q    <= '0;
            cols_din_q    <= '0;
            lbw_q         <= '0;
            rows_done_q   <= 1'b0;
            cols_done_q   <= 1'b0;
            frames_done_q <= '0;
            run_cnt_q     <= '0;
            err_q         <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            num_frames_q  <= num_frames_d;
            rows_din_q    <= rows_din_d;
            cols_din_q    <= cols_din_d;
            lbw_q         <= lbw_d;
            rows_done_q   <= rows_done_d;
            cols_done_q   <= cols_done_d;
            frames_done_q <= frames_done_d;
            run_cnt_q     <= run_cnt_d;
            err_q         <= err_d;
            stop_q        <= stop_d;
        end
    end

endmodule
